// File: rtl/ysyx_22040931_wb_queue.sv
// Write-back queue: DEPTH-entry FIFO between MEM and the shared regfile write port.
// Optional difftest trace ports are enabled with `define YSYX_22040931_WB_TRACE_EN.
module ysyx_22040931_wb_queue #(
    parameter int DATA_W = 64,
    parameter int PC_W   = 64,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_w_ena,
    input  logic [REG_AW-1:0] in_w_addr,
    input  logic [DATA_W-1:0] in_w_data,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              w_ready,
    output logic              w_ena,
    output logic [REG_AW-1:0] w_addr,
    output logic [DATA_W-1:0] w_data,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
    output logic [CNT_W-1:0]  commit_cnt,
    output logic              empty
`ifdef YSYX_22040931_WB_TRACE_EN
    ,
    output logic              commit_valid,
    output logic [PC_W-1:0]   commit_pc
`endif
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_Q_W = PTR_W + 1;
    localparam logic [CNT_Q_W-1:0] FULL_C = CNT_Q_W'(DEPTH);

    // A write to x0 is architecturally a no-op, so it never reaches the port or forwarding.
    function automatic logic is_rd_write(input logic ena, input logic [REG_AW-1:0] addr);
        return ena & (addr != {REG_AW{1'b0}});
    endfunction

    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [CNT_Q_W-1:0] count_r;
    logic [CNT_W-1:0]   commit_cnt_r;

    logic               ent_ena_r  [DEPTH];
    logic [REG_AW-1:0]  ent_addr_r [DEPTH];
    logic [DATA_W-1:0]  ent_data_r [DEPTH];

    logic               empty_s;
    logic               full_s;
    logic               push_s;
    logic               pop_s;
    logic               head_ena_s;
    logic [REG_AW-1:0]  head_addr_s;
    logic [DATA_W-1:0]  head_data_s;
    logic               head_wr_s;

    assign empty_s = (count_r == {CNT_Q_W{1'b0}});
    assign full_s  = (count_r == FULL_C);
    assign push_s  = in_valid & ~full_s;
    assign pop_s   = ~empty_s & w_ready;

    // Pointer and occupancy control; flush overrides any same-cycle push or pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_Q_W{1'b0}};
        end else if (flush) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_Q_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_Q_W'(1);
                2'b01:   count_r <= count_r - CNT_Q_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; a flushed push is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_ena_r[i]  <= 1'b0;
                ent_addr_r[i] <= {REG_AW{1'b0}};
                ent_data_r[i] <= {DATA_W{1'b0}};
            end
        end else if (push_s && !flush) begin
            ent_ena_r[wr_ptr_r]  <= in_w_ena;
            ent_addr_r[wr_ptr_r] <= in_w_addr;
            ent_data_r[wr_ptr_r] <= in_w_data;
        end
    end

    // Commit counter; a pop in the flush cycle has already been presented on w_*.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            commit_cnt_r <= {CNT_W{1'b0}};
        end else if (pop_s) begin
            commit_cnt_r <= commit_cnt_r + CNT_W'(1);
        end
    end

    // Head view, zeroed while the queue is empty.
    always_comb begin
        head_ena_s  = 1'b0;
        head_addr_s = {REG_AW{1'b0}};
        head_data_s = {DATA_W{1'b0}};
        if (!empty_s) begin
            head_ena_s  = ent_ena_r[rd_ptr_r];
            head_addr_s = ent_addr_r[rd_ptr_r];
            head_data_s = ent_data_r[rd_ptr_r];
        end else begin
            head_ena_s  = 1'b0;
            head_addr_s = {REG_AW{1'b0}};
            head_data_s = {DATA_W{1'b0}};
        end
    end

    assign head_wr_s  = is_rd_write(head_ena_s, head_addr_s);

    assign in_ready   = ~full_s;
    assign empty      = empty_s;
    assign w_ena      = head_wr_s & w_ready;
    assign w_addr     = head_addr_s;
    assign w_data     = head_data_s;
    assign fwd_valid  = head_wr_s;
    assign fwd_addr   = head_addr_s;
    assign fwd_data   = head_data_s;
    assign commit_cnt = commit_cnt_r;

`ifdef YSYX_22040931_WB_TRACE_EN
    logic [PC_W-1:0] ent_pc_r [DEPTH];

    // PC storage for difftest, written alongside the entry payload.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_pc_r[i] <= {PC_W{1'b0}};
            end
        end else if (push_s && !flush) begin
            ent_pc_r[wr_ptr_r] <= in_pc;
        end
    end

    assign commit_valid = pop_s;
    assign commit_pc    = empty_s ? {PC_W{1'b0}} : ent_pc_r[rd_ptr_r];
`else
    logic unused_pc_s;
    assign unused_pc_s = ^in_pc;
`endif

endmodule

// File: tb/tb_ysyx_22040931_wb_queue.sv
// Directed bench for ysyx_22040931_wb_queue: a DEPTH=2 instance plus a CNT_W=4 instance for wrap.
module tb_ysyx_22040931_wb_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_valid4 = 1'b0;
    logic        in_w_ena = 1'b0;
    logic [4:0]  in_w_addr = 5'd0;
    logic [63:0] in_w_data = 64'd0;
    logic [63:0] in_pc = 64'd0;
    logic        w_ready = 1'b0;

    logic        in_ready, w_ena, fwd_valid, empty;
    logic [4:0]  w_addr, fwd_addr;
    logic [63:0] w_data, fwd_data;
    logic [31:0] commit_cnt;

    logic        in_ready4, w_ena4, fwd_valid4, empty4;
    logic [4:0]  w_addr4, fwd_addr4;
    logic [63:0] w_data4, fwd_data4;
    logic [3:0]  commit_cnt4;
`ifdef YSYX_22040931_WB_TRACE_EN
    logic        commit_valid, commit_valid4;
    logic [63:0] commit_pc, commit_pc4;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_22040931_wb_queue dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_w_ena(in_w_ena), .in_w_addr(in_w_addr), .in_w_data(in_w_data), .in_pc(in_pc),
        .w_ready(w_ready), .w_ena(w_ena), .w_addr(w_addr), .w_data(w_data),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .commit_cnt(commit_cnt), .empty(empty)
`ifdef YSYX_22040931_WB_TRACE_EN
        , .commit_valid(commit_valid), .commit_pc(commit_pc)
`endif
    );

    ysyx_22040931_wb_queue #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .flush(1'b0), .in_valid(in_valid4), .in_ready(in_ready4),
        .in_w_ena(in_w_ena), .in_w_addr(in_w_addr), .in_w_data(in_w_data), .in_pc(in_pc),
        .w_ready(1'b1), .w_ena(w_ena4), .w_addr(w_addr4), .w_data(w_data4),
        .fwd_valid(fwd_valid4), .fwd_addr(fwd_addr4), .fwd_data(fwd_data4),
        .commit_cnt(commit_cnt4), .empty(empty4)
`ifdef YSYX_22040931_WB_TRACE_EN
        , .commit_valid(commit_valid4), .commit_pc(commit_pc4)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic v, input logic ena, input logic [4:0] a, input logic [63:0] d);
        in_valid  = v;
        in_w_ena  = ena;
        in_w_addr = a;
        in_w_data = d;
    endtask

    initial begin
        // reset state
        #12 rst = 1'b0;
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_w_ena", 64'(w_ena), 64'd0);
        chk("rst_w_addr", 64'(w_addr), 64'd0);
        chk("rst_w_data", w_data, 64'd0);
        chk("rst_fwd_valid", 64'(fwd_valid), 64'd0);
        chk("rst_commit", 64'(commit_cnt), 64'd0);

        // single op passes through with one cycle of latency
        w_ready = 1'b1;
        set_op(1'b1, 1'b1, 5'd5, 64'hDEAD);
        tick();
        in_valid = 1'b0;
        #1;
        chk("t2_w_ena", 64'(w_ena), 64'd1);
        chk("t2_w_addr", 64'(w_addr), 64'd5);
        chk("t2_w_data", w_data, 64'hDEAD);
        chk("t2_fwd_valid", 64'(fwd_valid), 64'd1);
        chk("t2_fwd_addr", 64'(fwd_addr), 64'd5);
        tick();
        chk("t2_empty", 64'(empty), 64'd1);
        chk("t2_commit", 64'(commit_cnt), 64'd1);

        // fill under stall, third op held, drain in order
        w_ready = 1'b0;
        set_op(1'b1, 1'b1, 5'd1, 64'h11);
        tick();
        chk("t3_ready_1", 64'(in_ready), 64'd1);
        set_op(1'b1, 1'b1, 5'd2, 64'h22);
        tick();
        chk("t3_ready_full", 64'(in_ready), 64'd0);
        set_op(1'b1, 1'b1, 5'd3, 64'h33);
        tick();
        chk("t3_head_addr", 64'(w_addr), 64'd1);
        chk("t3_head_data", w_data, 64'h11);
        chk("t3_stall_w_ena", 64'(w_ena), 64'd0);
        chk("t3_stall_fwd", 64'(fwd_valid), 64'd1);
        w_ready = 1'b1;
        #1;
        chk("t3_w_ena_1", 64'(w_ena), 64'd1);
        tick();
        chk("t3_addr_2", 64'(w_addr), 64'd2);
        chk("t3_data_2", w_data, 64'h22);
        chk("t3_ready_after_pop", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        #1;
        chk("t3_addr_3", 64'(w_addr), 64'd3);
        chk("t3_data_3", w_data, 64'h33);
        chk("t3_commit_mid", 64'(commit_cnt), 64'd3);
        tick();
        chk("t3_empty", 64'(empty), 64'd1);
        chk("t3_commit", 64'(commit_cnt), 64'd4);

        // x0 write suppressed but still committed
        set_op(1'b1, 1'b1, 5'd0, 64'd7);
        tick();
        in_valid = 1'b0;
        #1;
        chk("t4_w_ena", 64'(w_ena), 64'd0);
        chk("t4_fwd_valid", 64'(fwd_valid), 64'd0);
        chk("t4_w_data", w_data, 64'd7);
        chk("t4_not_empty", 64'(empty), 64'd0);
        tick();
        chk("t4_empty", 64'(empty), 64'd1);
        chk("t4_commit", 64'(commit_cnt), 64'd5);

        // flush a full queue with a push pending and the port stalled
        w_ready = 1'b0;
        set_op(1'b1, 1'b1, 5'd6, 64'h66);
        tick();
        set_op(1'b1, 1'b1, 5'd7, 64'h77);
        tick();
        chk("t5_full", 64'(in_ready), 64'd0);
        set_op(1'b1, 1'b1, 5'd8, 64'h88);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("t5_empty", 64'(empty), 64'd1);
        chk("t5_in_ready", 64'(in_ready), 64'd1);
        chk("t5_w_ena", 64'(w_ena), 64'd0);
        chk("t5_commit", 64'(commit_cnt), 64'd5);

        // pop in the flush cycle still writes and counts
        set_op(1'b1, 1'b1, 5'd9, 64'h99);
        tick();
        in_valid = 1'b0;
        flush = 1'b1;
        w_ready = 1'b1;
        #1;
        chk("t5b_w_ena", 64'(w_ena), 64'd1);
        chk("t5b_w_addr", 64'(w_addr), 64'd9);
        tick();
        flush = 1'b0;
        #1;
        chk("t5b_empty", 64'(empty), 64'd1);
        chk("t5b_commit", 64'(commit_cnt), 64'd6);

        // asynchronous reset mid-operation
        w_ready = 1'b0;
        set_op(1'b1, 1'b1, 5'd10, 64'hAA);
        tick();
        in_valid = 1'b0;
        chk("ar_pending", 64'(empty), 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("ar_empty", 64'(empty), 64'd1);
        chk("ar_commit", 64'(commit_cnt), 64'd0);
        chk("ar_fwd", 64'(fwd_valid), 64'd0);
        #3 rst = 1'b0;
        tick();

        // commit counter wrap on the 4-bit instance
        set_op(1'b0, 1'b1, 5'd4, 64'h44);
        in_valid4 = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        in_valid4 = 1'b0;
        tick();
        chk("t6_cnt_15", 64'(commit_cnt4), 64'd15);
        chk("t6_empty", 64'(empty4), 64'd1);
        in_pc = 64'h1000;
        in_valid4 = 1'b1;
        tick();
        in_pc = 64'h2000;
        #1;
        chk("t6_cnt_hold", 64'(commit_cnt4), 64'd15);
`ifdef YSYX_22040931_WB_TRACE_EN
        chk("t6_cv_1", 64'(commit_valid4), 64'd1);
        chk("t6_pc_1", commit_pc4, 64'h1000);
`endif
        tick();
        in_valid4 = 1'b0;
        #1;
        chk("t6_cnt_wrap", 64'(commit_cnt4), 64'd0);
`ifdef YSYX_22040931_WB_TRACE_EN
        chk("t6_cv_2", 64'(commit_valid4), 64'd1);
        chk("t6_pc_2", commit_pc4, 64'h2000);
`endif
        tick();
        chk("t6_cnt_1", 64'(commit_cnt4), 64'd1);
        chk("t6_empty_end", 64'(empty4), 64'd1);
`ifdef YSYX_22040931_WB_TRACE_EN
        chk("t6_cv_end", 64'(commit_valid4), 64'd0);
        chk("t6_pc_end", commit_pc4, 64'd0);
`endif
        chk("t6_main_idle", 64'(commit_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
